// File: rtl/risc_pkg.sv
// risc_pkg: opcode map, instruction field positions, instruction classes and
// the control records carried down the pipeline.
package risc_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_DIV  = 6'b000011;
  localparam logic [5:0] OP_LSFT = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b100001;
  localparam logic [5:0] OP_SUBI = 6'b100010;
  localparam logic [5:0] OP_MULI = 6'b100011;
  localparam logic [5:0] OP_DIVI = 6'b100100;
  localparam logic [5:0] OP_LW   = 6'b101000;
  localparam logic [5:0] OP_SW   = 6'b101001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {C_RR, C_RI, C_LD, C_ST, C_HLT, C_ILL} iclass_t;

  // Full decoded control, held in ID/EX where operand indices are still needed.
  typedef struct packed {
    logic       valid;
    iclass_t    cls;
    logic [5:0] op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       we;
  } ctrl_t;

  // Reduced control for EX/MEM and MEM/WB: only what forwarding and retire use.
  typedef struct packed {
    logic       valid;
    iclass_t    cls;
    logic [4:0] rd;
    logic       we;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_NOP = '{valid: 1'b0, cls: C_ILL, op: OP_ADD,
                                 rd: 5'd0, rs: 5'd0, rt: 5'd0, we: 1'b0};
  localparam wb_ctrl_t WB_NOP = '{valid: 1'b0, cls: C_ILL, rd: 5'd0, we: 1'b0};

  function automatic iclass_t op_class(input logic [5:0] op);
    iclass_t c;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LSFT: c = C_RR;
      OP_ADDI, OP_SUBI, OP_MULI, OP_DIVI:      c = C_RI;
      OP_LW:                                   c = C_LD;
      OP_SW:                                   c = C_ST;
      OP_HALT:                                 c = C_HLT;
      default:                                 c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu: combinational execute unit. Divide by zero yields all-ones; shifts
// use only the low log2(DATA_W) bits of the amount. LW/SW reuse ADD for addresses.
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // operation select
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
      OP_SUB, OP_SUBI:               result = a - b;
      OP_MUL, OP_MULI:               result = a * b;
      OP_DIV, OP_DIVI:               result = (b == '0) ? '1 : a / b;
      OP_LSFT:                       result = a << shamt;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/risc_pipe_core.sv
// risc_pipe_core: 5-stage IF/ID/EX/MEM/WB pipeline with full forwarding into
// EX, one-cycle load-use stall, halt drain, program-load and debug read ports.
module risc_pipe_core
  import risc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int MEM_DEPTH = 64,
  parameter int CNT_W     = 16,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [AW-1:0]     pc_o,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  logic [DATA_W-1:0] mem  [MEM_DEPTH];
  logic [DATA_W-1:0] regs [NREG];

  logic [AW-1:0]     pc, pc_next;
  logic              stop_fetch;
  logic              ifid_valid;
  logic [31:0]       ifid_instr;
  ctrl_t             idex_c, id_c;
  logic [DATA_W-1:0] idex_a, idex_b, idex_d, idex_imm;
  wb_ctrl_t          exmem_c, memwb_c;
  logic [DATA_W-1:0] exmem_res, exmem_sd, memwb_res;

  logic [DATA_W-1:0] fetch_word, id_a, id_b, id_d, id_imm;
  logic [DATA_W-1:0] ex_a, ex_rt, ex_sd, alu_b, ex_res;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata, wb_next;
  logic              halt_id, load_use, fetch_en, mem_st;
  logic [5:0]        id_op;
  iclass_t           id_cls;

  // Regfile read for ID: WB result is visible in the same cycle.
  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NREG) return '0;
    if (memwb_c.valid && memwb_c.we && memwb_c.rd == idx) return memwb_res;
    return regs[idx];
  endfunction

  // EX operand select: younger producer (EX/MEM) wins over MEM/WB.
  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] idx,
                                            input logic [DATA_W-1:0] rf_val);
    if (exmem_c.valid && exmem_c.we && exmem_c.rd == idx) return exmem_res;
    if (memwb_c.valid && memwb_c.we && memwb_c.rd == idx) return memwb_res;
    return rf_val;
  endfunction

  assign pc_o       = pc;
  assign pc_next    = (pc == AW'(MEM_DEPTH - 1)) ? '0 : pc + AW'(1);
  assign fetch_word = mem[pc];
  assign dbg_data   = (dbg_addr == 5'd0 || int'(dbg_addr) >= NREG) ? '0 : regs[dbg_addr];

  assign id_op  = ifid_instr[OP_HI:OP_LO];
  assign id_cls = op_class(id_op);
  assign id_imm = {{(DATA_W-16){ifid_instr[IMM_HI]}}, ifid_instr[IMM_HI:IMM_LO]};

  // decode of the instruction held in IF/ID
  always_comb begin
    id_c       = CTRL_NOP;
    id_c.valid = ifid_valid;
    id_c.cls   = id_cls;
    id_c.op    = id_op;
    id_c.rd    = ifid_instr[RD_HI:RD_LO];
    id_c.rs    = ifid_instr[RS_HI:RS_LO];
    id_c.rt    = ifid_instr[RT_HI:RT_LO];
    id_c.we    = ifid_valid && (id_cls == C_RR || id_cls == C_RI || id_cls == C_LD) &&
                 id_c.rd != 5'd0 && int'(id_c.rd) < NREG;
  end

  assign id_a = rf_read(id_c.rs);
  assign id_b = rf_read(id_c.rt);
  assign id_d = rf_read(id_c.rd);

  // SW consumes its rd as store data, so it joins rs/rt in the stall check.
  assign halt_id  = ifid_valid && id_cls == C_HLT;
  assign load_use = ifid_valid && idex_c.valid && idex_c.cls == C_LD && idex_c.we &&
                    ((id_c.rs == idex_c.rd) ||
                     (id_cls == C_RR && id_c.rt == idex_c.rd) ||
                     (id_cls == C_ST && id_c.rd == idex_c.rd));
  assign fetch_en = run && !halted && !stop_fetch && !halt_id && !load_use;

  assign ex_a  = fwd(idex_c.rs, idex_a);
  assign ex_rt = fwd(idex_c.rt, idex_b);
  assign ex_sd = fwd(idex_c.rd, idex_d);
  assign alu_b = (idex_c.cls == C_RR) ? ex_rt : idex_imm;

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (idex_c.op),
    .a      (ex_a),
    .b      (alu_b),
    .result (ex_res)
  );

  assign mem_addr  = exmem_res[AW-1:0];
  assign mem_rdata = mem[mem_addr];
  assign mem_st    = exmem_c.valid && exmem_c.cls == C_ST && !rst;
  assign wb_next   = (exmem_c.cls == C_LD) ? mem_rdata : exmem_res;

  // unified memory: SW at end of MEM, program loading only while idle
  always_ff @(posedge clk) begin
    if (mem_st) begin
      mem[mem_addr] <= exmem_sd;
    end else if (prog_we && !run) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // register file write at WB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (memwb_c.valid && memwb_c.we) begin
      regs[memwb_c.rd] <= memwb_res;
    end
  end

  // pipeline advance, fetch control and retire status
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      stop_fetch <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      idex_c     <= CTRL_NOP;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_d     <= '0;
      idex_imm   <= '0;
      exmem_c    <= WB_NOP;
      exmem_res  <= '0;
      exmem_sd   <= '0;
      memwb_c    <= WB_NOP;
      memwb_res  <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      retired    <= '0;
    end else begin
      if (!load_use) begin
        if (fetch_en) begin
          pc         <= pc_next;
          ifid_valid <= 1'b1;
          ifid_instr <= fetch_word[31:0];
        end else begin
          ifid_valid <= 1'b0;
        end
      end
      if (halt_id) stop_fetch <= 1'b1;
      idex_c    <= load_use ? CTRL_NOP : id_c;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_d    <= id_d;
      idex_imm  <= id_imm;
      exmem_c   <= '{valid: idex_c.valid, cls: idex_c.cls, rd: idex_c.rd, we: idex_c.we};
      exmem_res <= ex_res;
      exmem_sd  <= ex_sd;
      memwb_c   <= exmem_c;
      memwb_res <= wb_next;
      if (memwb_c.valid) begin
        if (memwb_c.cls == C_HLT) begin
          halted <= 1'b1;
        end else if (retired != '1) begin
          retired <= retired + CNT_W'(1);
        end
        if (memwb_c.cls == C_ILL) illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_risc_pipe_core.sv
// Directed testbench for risc_pipe_core: one task per scenario, expected
// values computed by hand from the instruction semantics.
module tb_risc_pipe_core;

  localparam int DATA_W    = 32;
  localparam int NREG      = 32;
  localparam int MEM_DEPTH = 64;
  localparam int CNT_W     = 16;
  localparam int AW        = 6;

  localparam logic [5:0] ADD  = 6'b000000, SUB  = 6'b000001, MUL  = 6'b000010;
  localparam logic [5:0] DIV  = 6'b000011, LSFT = 6'b000100, ADDI = 6'b100001;
  localparam logic [5:0] DIVI = 6'b100100, LW   = 6'b101000, SW   = 6'b101001;
  localparam logic [31:0] HALT_W = {6'b111111, 26'd0};
  localparam logic [31:0] ILL_W  = {6'b011111, 5'd5, 5'd0, 16'd1};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              prog_we = 1'b0;
  logic [AW-1:0]     prog_addr = '0;
  logic [DATA_W-1:0] prog_wdata = '0;
  logic [4:0]        dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;
  logic [AW-1:0]     pc_o;
  logic              halted;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] prog [16];
  int prog_n = 0;

  always #5 clk = ~clk;

  risc_pipe_core #(
    .DATA_W(DATA_W), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .pc_o       (pc_o),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic load_prog();
    rst = 1'b1;
    run = 1'b0;
    for (int i = 0; i < prog_n; i++) begin
      prog_we    = 1'b1;
      prog_addr  = AW'(i);
      prog_wdata = prog[i];
      step();
    end
    prog_we = 1'b0;
    step();
  endtask

  task automatic go();
    rst = 1'b0;
    run = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_halt(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (halted === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [DATA_W-1:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] v;
    rst = 1'b1;
    run = 1'b0;
    step();
    step();
    tests++; if (pc_o !== 6'd0) begin fails++; $display("FAIL reset_pc: got %0d expected 0", pc_o); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    tests++; if (retired !== 16'd0) begin fails++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    read_reg(5'd3, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL reset_r3: got %h expected 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    int at;
    prog[0] = enc_i(ADDI, 5'd1, 5'd0, 16'd5);
    prog[1] = enc_i(ADDI, 5'd2, 5'd0, 16'd7);
    prog[2] = enc_r(ADD, 5'd3, 5'd1, 5'd2);
    prog[3] = HALT_W;
    prog_n = 4;
    load_prog();
    go();
    wait_halt(40, at);
    tests++; if (at !== 8) begin fails++; $display("FAIL b2b_halt_cycle: got %0d expected 8", at); end
    read_reg(5'd3, v);
    tests++; if (v !== 32'd12) begin fails++; $display("FAIL b2b_r3: got %0d expected 12", v); end
    read_reg(5'd1, v);
    tests++; if (v !== 32'd5) begin fails++; $display("FAIL b2b_r1: got %0d expected 5", v); end
    tests++; if (retired !== 16'd3) begin fails++; $display("FAIL b2b_retired: got %0d expected 3", retired); end
  endtask

  task automatic test_load_use();
    logic [DATA_W-1:0] v;
    int at_nodep, at_dep;
    prog[0] = enc_i(ADDI, 5'd1, 5'd0, 16'd9);
    prog[1] = enc_i(SW,   5'd1, 5'd0, 16'd20);
    prog[2] = enc_i(LW,   5'd4, 5'd0, 16'd20);
    prog[3] = enc_r(ADD,  5'd5, 5'd1, 5'd1);
    prog[4] = HALT_W;
    prog_n = 5;
    load_prog();
    go();
    wait_halt(40, at_nodep);
    tests++; if (at_nodep !== 9) begin fails++; $display("FAIL ld_nodep_halt_cycle: got %0d expected 9", at_nodep); end
    prog[3] = enc_r(ADD, 5'd5, 5'd4, 5'd4);
    load_prog();
    go();
    wait_halt(40, at_dep);
    tests++; if (at_dep !== 10) begin fails++; $display("FAIL ld_dep_halt_cycle: got %0d expected 10", at_dep); end
    read_reg(5'd5, v);
    tests++; if (v !== 32'd18) begin fails++; $display("FAIL ld_r5: got %0d expected 18", v); end
    read_reg(5'd4, v);
    tests++; if (v !== 32'd9) begin fails++; $display("FAIL ld_r4_mem20: got %0d expected 9", v); end
  endtask

  task automatic test_halt_squash();
    logic [DATA_W-1:0] v;
    int at;
    prog[0] = HALT_W;
    prog[1] = enc_i(ADDI, 5'd6, 5'd0, 16'd1);
    prog_n = 2;
    load_prog();
    go();
    wait_halt(20, at);
    tests++; if (at !== 5) begin fails++; $display("FAIL squash_halt_cycle: got %0d expected 5", at); end
    for (int i = 0; i < 20; i++) step();
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL squash_halted_sticky: got %b expected 1", halted); end
    tests++; if (pc_o !== 6'd1) begin fails++; $display("FAIL squash_pc: got %0d expected 1", pc_o); end
    read_reg(5'd6, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL squash_r6: got %0d expected 0", v); end
    tests++; if (retired !== 16'd0) begin fails++; $display("FAIL squash_retired: got %0d expected 0", retired); end
  endtask

  task automatic test_arith();
    logic [DATA_W-1:0] v;
    int at;
    prog[0]  = enc_i(DIVI, 5'd1,  5'd0, 16'd0);
    prog[1]  = enc_i(ADDI, 5'd2,  5'd0, 16'd3);
    prog[2]  = enc_i(ADDI, 5'd3,  5'd0, 16'd33);
    prog[3]  = enc_r(LSFT, 5'd4,  5'd2, 5'd3);
    prog[4]  = enc_i(ADDI, 5'd7,  5'd0, 16'hFFFF);
    prog[5]  = enc_i(ADDI, 5'd0,  5'd0, 16'd5);
    prog[6]  = enc_r(ADD,  5'd11, 5'd0, 5'd0);
    prog[7]  = enc_r(SUB,  5'd8,  5'd2, 5'd3);
    prog[8]  = enc_r(MUL,  5'd9,  5'd2, 5'd3);
    prog[9]  = enc_r(DIV,  5'd10, 5'd3, 5'd2);
    prog[10] = HALT_W;
    prog_n = 11;
    load_prog();
    go();
    wait_halt(60, at);
    tests++; if (at !== 15) begin fails++; $display("FAIL arith_halt_cycle: got %0d expected 15", at); end
    read_reg(5'd1, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL arith_divi0: got %h expected ffffffff", v); end
    read_reg(5'd4, v);
    tests++; if (v !== 32'd6) begin fails++; $display("FAIL arith_lsft_wrap: got %0d expected 6", v); end
    read_reg(5'd7, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL arith_sext: got %h expected ffffffff", v); end
    read_reg(5'd0, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL arith_r0: got %h expected 0", v); end
    read_reg(5'd11, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL arith_r0_fwd: got %h expected 0", v); end
    read_reg(5'd8, v);
    tests++; if (v !== 32'hFFFF_FFE2) begin fails++; $display("FAIL arith_sub: got %h expected ffffffe2", v); end
    read_reg(5'd9, v);
    tests++; if (v !== 32'd99) begin fails++; $display("FAIL arith_mul: got %0d expected 99", v); end
    read_reg(5'd10, v);
    tests++; if (v !== 32'd11) begin fails++; $display("FAIL arith_div: got %0d expected 11", v); end
    tests++; if (retired !== 16'd10) begin fails++; $display("FAIL arith_retired: got %0d expected 10", retired); end
  endtask

  task automatic test_run_gating();
    logic [DATA_W-1:0] v;
    int at;
    prog[0] = enc_i(ADDI, 5'd1, 5'd0, 16'd1);
    prog[1] = enc_i(ADDI, 5'd2, 5'd1, 16'd2);
    prog[2] = enc_i(ADDI, 5'd3, 5'd2, 16'd3);
    prog[3] = enc_i(ADDI, 5'd4, 5'd3, 16'd4);
    prog[4] = enc_i(ADDI, 5'd5, 5'd4, 16'd5);
    prog[5] = HALT_W;
    prog_n = 6;
    load_prog();
    go();
    step();
    step();
    step();
    run = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tests++; if (pc_o !== 6'd3) begin fails++; $display("FAIL gate_pc_hold: got %0d expected 3", pc_o); end
    tests++; if (retired !== 16'd3) begin fails++; $display("FAIL gate_drain_retired: got %0d expected 3", retired); end
    read_reg(5'd3, v);
    tests++; if (v !== 32'd6) begin fails++; $display("FAIL gate_r3: got %0d expected 6", v); end
    read_reg(5'd4, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL gate_r4_not_yet: got %0d expected 0", v); end
    run = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = 6'd4;
    prog_wdata = enc_i(ADDI, 5'd5, 5'd0, 16'd100);
    step();
    prog_we = 1'b0;
    wait_halt(40, at);
    tests++; if (at === -1) begin fails++; $display("FAIL gate_halt_timeout: got %0d expected >0", at); end
    read_reg(5'd5, v);
    tests++; if (v !== 32'd15) begin fails++; $display("FAIL gate_prog_we_ignored: got %0d expected 15", v); end
    tests++; if (retired !== 16'd5) begin fails++; $display("FAIL gate_retired: got %0d expected 5", retired); end
  endtask

  task automatic test_illegal_reset();
    logic [DATA_W-1:0] v;
    int at;
    prog[0] = ILL_W;
    prog[1] = enc_i(ADDI, 5'd1, 5'd0, 16'd4);
    prog[2] = enc_i(ADDI, 5'd2, 5'd1, 16'd5);
    prog[3] = enc_r(ADD,  5'd3, 5'd1, 5'd2);
    prog[4] = HALT_W;
    prog_n = 5;
    load_prog();
    go();
    for (int i = 0; i < 6; i++) step();
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_flag: got %b expected 1", illegal); end
    tests++; if (retired !== 16'd2) begin fails++; $display("FAIL ill_retired_mid: got %0d expected 2", retired); end
    read_reg(5'd1, v);
    tests++; if (v !== 32'd4) begin fails++; $display("FAIL ill_r1_mid: got %0d expected 4", v); end
    rst = 1'b1;
    step();
    tests++; if (pc_o !== 6'd0) begin fails++; $display("FAIL rst_mid_pc: got %0d expected 0", pc_o); end
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL rst_mid_illegal: got %b expected 0", illegal); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_mid_halted: got %b expected 0", halted); end
    tests++; if (retired !== 16'd0) begin fails++; $display("FAIL rst_mid_retired: got %0d expected 0", retired); end
    read_reg(5'd1, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL rst_mid_r1: got %0d expected 0", v); end
    rst = 1'b0;
    wait_halt(40, at);
    tests++; if (at === -1) begin fails++; $display("FAIL rst_rerun_timeout: got %0d expected >0", at); end
    read_reg(5'd3, v);
    tests++; if (v !== 32'd13) begin fails++; $display("FAIL rst_rerun_r3: got %0d expected 13", v); end
    read_reg(5'd5, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL ill_no_write_r5: got %0d expected 0", v); end
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL rst_rerun_illegal: got %b expected 1", illegal); end
    tests++; if (retired !== 16'd4) begin fails++; $display("FAIL rst_rerun_retired: got %0d expected 4", retired); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_halt_squash();
    test_arith();
    test_run_gating();
    test_illegal_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
